// File: rtl/prog_mem_pkg.sv
// Shared state encoding, default geometry and address-width helper for the program memory.
package prog_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam int              DEF_WIDTH        = 21;
    localparam int              DEF_DEPTH        = 16;
    localparam logic [20:0]     DEF_DEFAULT_WORD = '0;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Fetch and load signal bundle between a program-memory client (master) and the memory (slave).
interface prog_mem_if
    import prog_mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [15:0]      addr;
    logic             rd_en;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             addr_err;
    logic             ld_start;
    logic [15:0]      ld_base;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             busy;
    logic [15:0]      ld_count;
    logic             ld_err;

    modport master (
        output addr, rd_en, ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  data, data_valid, addr_err, ld_ready, busy, ld_count, ld_err
    );

    modport slave (
        input  addr, rd_en, ld_start, ld_base, ld_valid, ld_data, ld_last,
        output data, data_valid, addr_err, ld_ready, busy, ld_count, ld_err
    );
endinterface

// File: rtl/prog_mem_array.sv
// Word storage: one write port, one registered read port (1-cycle latency), no backpressure.
// The read register is cleared by rst; the array contents never are.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               DEPTH        = DEF_DEPTH,
    parameter logic [WIDTH-1:0] DEFAULT_WORD = WIDTH'(DEF_DEFAULT_WORD),
    parameter int               AW           = addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             rdef,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdef substitutes the default word so out-of-range fetches never index mem.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= DEFAULT_WORD;
        end else if (re) begin
            rdata <= rdef ? DEFAULT_WORD : mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a streaming load session and 1-cycle registered fetch.
// Load words are accepted every cycle while busy; fetches are only served while idle.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               DEPTH        = DEF_DEPTH,
    parameter logic [WIDTH-1:0] DEFAULT_WORD = WIDTH'(DEF_DEFAULT_WORD)
) (
    input  logic       clk,
    input  logic       rst,
    prog_mem_if.slave  bus
);

    localparam int          AW      = addr_bits(DEPTH);
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [16:0] ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        valid_q, oob_q;
    logic        fetch, wr_en, fetch_oob;

    assign fetch_oob = ({1'b0, bus.addr} >= DEPTH17);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fetch   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                fetch = bus.rd_en;
                if (bus.ld_start) begin
                    state_d = LOAD;
                    ptr_d   = {1'b0, bus.ld_base};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    cnt_d = cnt_q + 16'd1;
                    // Saturate once past 64K so the pointer can never wrap back into range.
                    ptr_d = ptr_q[16] ? ptr_q : ptr_q + 17'd1;
                    if (ptr_q < DEPTH17) begin
                        wr_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.ld_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= fetch;
            oob_q   <= fetch & fetch_oob;
        end
    end

    prog_mem_array #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .DEFAULT_WORD (DEFAULT_WORD),
        .AW           (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en & ~rst),
        .waddr (ptr_q[AW-1:0]),
        .wdata (bus.ld_data),
        .re    (fetch),
        .rdef  (fetch_oob),
        .raddr (bus.addr[AW-1:0]),
        .rdata (bus.data)
    );

    assign bus.data_valid = valid_q;
    assign bus.addr_err   = oob_q;
    assign bus.busy       = (state_q == LOAD);
    assign bus.ld_ready   = (state_q == LOAD);
    assign bus.ld_count   = cnt_q;
    assign bus.ld_err     = err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem (WIDTH=21, DEPTH=16): load sessions, fetches, range errors, reset abort.
module tb_prog_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    prog_mem_if #(.WIDTH(21)) bus ();

    prog_mem #(.WIDTH(21), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.addr     = '0;
        bus.rd_en    = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_data",     32'(bus.data), 32'h0);
        check("rst_valid",    32'(bus.data_valid), 32'h0);
        check("rst_addr_err", 32'(bus.addr_err), 32'h0);
        check("rst_busy",     32'(bus.busy), 32'h0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'h0);
        check("rst_ld_count", 32'(bus.ld_count), 32'h0);
        check("rst_ld_err",   32'(bus.ld_err), 32'h0);

        // Initial contents are the default word
        bus.rd_en = 1'b1; bus.addr = 16'd3;
        tick();
        check("init_data",  32'(bus.data), 32'h0);
        check("init_valid", 32'(bus.data_valid), 32'h1);
        bus.rd_en = 1'b0;

        // Full load 1..16 at base 0
        bus.ld_start = 1'b1; bus.ld_base = 16'd0;
        tick();
        bus.ld_start = 1'b0;
        check("load_busy",     32'(bus.busy), 32'h1);
        check("load_ready",    32'(bus.ld_ready), 32'h1);
        check("load_cnt0",     32'(bus.ld_count), 32'h0);
        check("load_no_valid", 32'(bus.data_valid), 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 21'(i + 1);
            bus.ld_last  = (i == 15);
            tick();
            if (i == 7) begin
                check("load_cnt8",  32'(bus.ld_count), 32'd8);
                check("load_busy8", 32'(bus.busy), 32'h1);
            end
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        check("full_cnt",  32'(bus.ld_count), 32'd16);
        check("full_busy", 32'(bus.busy), 32'h0);
        check("full_err",  32'(bus.ld_err), 32'h0);

        // Back-to-back fetches
        bus.rd_en = 1'b1; bus.addr = 16'd5;
        tick();
        check("f5_data",  32'(bus.data), 32'd6);
        check("f5_valid", 32'(bus.data_valid), 32'h1);
        check("f5_err",   32'(bus.addr_err), 32'h0);
        bus.addr = 16'd15;
        tick();
        check("f15_data",  32'(bus.data), 32'd16);
        check("f15_valid", 32'(bus.data_valid), 32'h1);
        bus.addr = 16'd0;
        tick();
        check("f0_data", 32'(bus.data), 32'd1);
        bus.rd_en = 1'b0;
        tick();
        check("idle_valid", 32'(bus.data_valid), 32'h0);
        check("idle_hold",  32'(bus.data), 32'd1);

        // Out-of-range fetch
        bus.rd_en = 1'b1; bus.addr = 16'd16;
        tick();
        check("oob_data",  32'(bus.data), 32'h0);
        check("oob_err",   32'(bus.addr_err), 32'h1);
        check("oob_valid", 32'(bus.data_valid), 32'h1);
        bus.rd_en = 1'b0;
        tick();
        check("oob_err_drop",   32'(bus.addr_err), 32'h0);
        check("oob_valid_drop", 32'(bus.data_valid), 32'h0);

        // Load crossing the end of memory
        bus.ld_start = 1'b1; bus.ld_base = 16'd14;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 21'(32'h100 + i);
            bus.ld_last  = (i == 3);
            tick();
            if (i == 1) check("edge_err_early", 32'(bus.ld_err), 32'h0);
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        check("edge_err",  32'(bus.ld_err), 32'h1);
        check("edge_cnt",  32'(bus.ld_count), 32'd4);
        check("edge_busy", 32'(bus.busy), 32'h0);
        bus.rd_en = 1'b1; bus.addr = 16'd14;
        tick();
        check("edge_m14", 32'(bus.data), 32'h100);
        bus.addr = 16'd15;
        tick();
        check("edge_m15", 32'(bus.data), 32'h101);
        bus.addr = 16'd0;
        tick();
        check("edge_m0", 32'(bus.data), 32'd1);
        bus.addr = 16'd1;
        tick();
        check("edge_m1", 32'(bus.data), 32'd2);
        bus.rd_en = 1'b0;

        // RD_EN held through a load session; stray LD_START ignored
        bus.ld_start = 1'b1; bus.ld_base = 16'd8;
        tick();
        bus.rd_en = 1'b1; bus.addr = 16'd3; bus.ld_base = 16'd0;
        bus.ld_valid = 1'b1; bus.ld_data = 21'h200;
        tick();
        bus.ld_start = 1'b0;
        check("rdload_valid0", 32'(bus.data_valid), 32'h0);
        check("rdload_hold",   32'(bus.data), 32'd2);
        check("rdload_cnt",    32'(bus.ld_count), 32'd1);
        bus.ld_data = 21'h201; bus.ld_last = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        check("rdload_valid1", 32'(bus.data_valid), 32'h0);
        check("rdload_idle",   32'(bus.busy), 32'h0);
        tick();
        check("rdload_first_valid", 32'(bus.data_valid), 32'h1);
        check("rdload_first_data",  32'(bus.data), 32'd4);
        bus.addr = 16'd9;
        tick();
        check("rdload_m9", 32'(bus.data), 32'h201);
        bus.rd_en = 1'b0;

        // Reset mid-load; rst beats a concurrent load word
        bus.ld_start = 1'b1; bus.ld_base = 16'd4;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 21'(32'h300 + i);
            tick();
        end
        rst = 1'b1; bus.ld_data = 21'h303;
        tick();
        rst = 1'b0; bus.ld_valid = 1'b0;
        check("abort_busy",  32'(bus.busy), 32'h0);
        check("abort_cnt",   32'(bus.ld_count), 32'h0);
        check("abort_data",  32'(bus.data), 32'h0);
        check("abort_valid", 32'(bus.data_valid), 32'h0);
        bus.rd_en = 1'b1; bus.addr = 16'd4;
        tick();
        check("abort_m4", 32'(bus.data), 32'h300);
        bus.addr = 16'd6;
        tick();
        check("abort_m6", 32'(bus.data), 32'h302);
        bus.addr = 16'd7;
        tick();
        check("abort_m7", 32'(bus.data), 32'd8);
        bus.rd_en = 1'b0;

        // Fetch and load start together
        bus.ld_start = 1'b1; bus.ld_base = 16'd2;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 21'd7; bus.ld_last = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        bus.rd_en = 1'b1; bus.addr = 16'd2; bus.ld_start = 1'b1; bus.ld_base = 16'd2;
        tick();
        bus.rd_en = 1'b0; bus.ld_start = 1'b0;
        check("both_data",  32'(bus.data), 32'd7);
        check("both_valid", 32'(bus.data_valid), 32'h1);
        check("both_busy",  32'(bus.busy), 32'h1);
        bus.ld_last = 1'b1;
        tick();
        check("lastnovalid_busy", 32'(bus.busy), 32'h1);
        bus.ld_valid = 1'b1; bus.ld_data = 21'd9;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        check("both_done_busy", 32'(bus.busy), 32'h0);
        check("both_done_cnt",  32'(bus.ld_count), 32'd1);
        bus.rd_en = 1'b1; bus.addr = 16'd2;
        tick();
        bus.rd_en = 1'b0;
        check("both_m2", 32'(bus.data), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 21, instruction word width in bits.
REQ-003 Parameter DEPTH, default 16, number of words stored (2..65536).
REQ-004 Parameter DEFAULT_WORD, default all-zero WIDTH bits, word returned for out-of-range fetch and initial contents.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 ADDR  input  16  fetch address.
REQ-008 RD_EN  input  1  fetch request, sampled at CLK edge.
REQ-009 data  output  WIDTH  registered fetch data.
REQ-010 data_valid  output  1  one-cycle pulse, data updated this cycle.
REQ-011 addr_err  output  1  one-cycle pulse accompanying data_valid when ADDR >= DEPTH.
REQ-012 LD_START  input  1  begin load session at LD_BASE.
REQ-013 LD_BASE  input  16  first load address.
REQ-014 LD_VALID  input  1  load word present.
REQ-015 LD_DATA  input  WIDTH  load word.
REQ-016 LD_LAST  input  1  qualifies final word of session.
REQ-017 ld_ready  output  1  block accepts load word.
REQ-018 busy  output  1  load session active.
REQ-019 ld_count  output  16  words accepted in current/last session.
REQ-020 ld_err  output  1  sticky: a load word targeted address >= DEPTH.

Function
REQ-021 States: IDLE, LOAD; busy = (state == LOAD); ld_ready = (state == LOAD).
REQ-022 IDLE + LD_START -> LOAD; pointer <= LD_BASE; ld_count <= 0; ld_err <= 0.
REQ-023 LOAD: each cycle with LD_VALID & ld_ready writes LD_DATA at pointer, pointer +1, ld_count +1 (wraps at 16 bits).
REQ-024 Load write with pointer >= DEPTH is dropped, ld_err <= 1, ld_count still increments.
REQ-025 LD_VALID & LD_LAST in LOAD: word handled per REQ-023/024, state -> IDLE next cycle.
REQ-026 LD_START in LOAD is ignored; LD_LAST without LD_VALID is ignored.
REQ-027 Fetch: RD_EN high in IDLE at edge N -> data = mem[ADDR] and data_valid = 1 after edge N (one-cycle latency).
REQ-028 Fetch with ADDR >= DEPTH -> data = DEFAULT_WORD, addr_err = 1, data_valid = 1.
REQ-029 RD_EN in LOAD is ignored: data_valid stays 0, data holds.
REQ-030 No fetch: data holds previous value; data_valid and addr_err low.
REQ-031 RD_EN and LD_START same cycle in IDLE: fetch served from pre-load contents, LOAD entered.
REQ-032 Back-to-back fetches SHALL be sustained at one per cycle.
REQ-033 Pointer SHALL be 17 bits internally so increment past 65535 does not wrap into valid range.

Reset
REQ-034 RST: state IDLE, data = DEFAULT_WORD, data_valid 0, addr_err 0, ld_count 0, ld_err 0, busy 0, ld_ready 0.
REQ-035 Memory contents SHALL NOT be altered by RST; initial contents all DEFAULT_WORD.
REQ-036 RST mid-load aborts session; words already written are retained.
REQ-037 RST SHALL take priority over all other inputs in the same cycle.

Structure
REQ-038 Package prog_mem_pkg SHALL hold state encoding (IDLE, LOAD) and default WIDTH/DEPTH/DEFAULT_WORD constants.
REQ-039 Storage SHALL be one sub-module prog_mem_array (single write, single registered read port), FSM and handshake in prog_mem.

Verification
REQ-040 Load LD_BASE=0, words 1..16 (LD_LAST on 16th) -> ld_count=16, busy low next cycle, fetch ADDR=5 gives data=6 one cycle later with data_valid.
REQ-041 Fetch ADDR=16 with DEPTH=16 -> data=DEFAULT_WORD, addr_err=1, data_valid=1 for exactly one cycle.
REQ-042 Load LD_BASE=14, 4 words -> addresses 14,15 written, ld_err=1, ld_count=4, addresses 0,1 unchanged.
REQ-043 RD_EN held high during LOAD -> no data_valid pulses; first pulse one cycle after return to IDLE.
REQ-044 RST asserted after 3 of 8 load words -> busy 0, ld_count 0; those 3 words readable, rest unchanged.
REQ-045 RD_EN and LD_START together, ADDR=2 holding 7, first load word 9 at base 2 -> data=7.
